single_freq_analyzer: RTL and testbench

Coherent single-tone I/Q detector. It is the receive-side counterpart of single_freq_synth_core: the synth generates a tone at `freq`, and this block measures amplitude and phase of that tone in a sample stream.
Each accepted sample is mixed with an internal cos/−sin LO at `freq` (phase accumulator plus quarter-wave LUT). Products are accumulated over a block of 2^BLOCK_LOG2 samples, then scaled and saturated to I/Q.
Output feeds the loop/control logic that consumes I/Q from the synth path.

---
 rtl/single_freq_analyzer_if.sv | 24 ++
 rtl/single_freq_analyzer.sv | 181 ++++++++++++++++++
 tb/tb_single_freq_analyzer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/single_freq_analyzer_if.sv
// Sample/result bundle for single_freq_analyzer: control and sample inputs, I/Q result outputs.
interface single_freq_analyzer_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned FREQ_W = 14
);
    logic                     clear;
    logic [FREQ_W-1:0]        freq;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] I;
    logic signed [DATA_W-1:0] Q;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output clear, freq, in_valid, in_data,
        input  I, Q, out_valid, busy
    );

    modport slave (
        input  clear, freq, in_valid, in_data,
        output I, Q, out_valid, busy
    );
endinterface

// File: rtl/single_freq_analyzer.sv
// Coherent single-tone I/Q detector: mixes samples with a cos/-sin LO and integrates per block.
// Optional round-half-up before the output shift: define SINGLE_FREQ_ANALYZER_ROUND_EN.
module single_freq_analyzer #(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned FREQ_W     = 14,
    parameter int unsigned LUT_ADDR_W = 8,
    parameter int unsigned LO_W       = 10,
    parameter int unsigned BLOCK_LOG2 = 10
) (
    input logic                   clk,
    input logic                   rst,
    single_freq_analyzer_if.slave bus
);
    localparam int unsigned IDX_W  = LUT_ADDR_W + 2;
    localparam int unsigned LUT_N  = 2 ** LUT_ADDR_W;
    localparam int unsigned PROD_W = DATA_W + LO_W;
    localparam int unsigned ACC_W  = PROD_W + BLOCK_LOG2;
    localparam int unsigned SHIFT  = BLOCK_LOG2 + LO_W - 2;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`ifdef SINGLE_FREQ_ANALYZER_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (SHIFT - 1));
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_t;

    // Elaboration-time quarter-wave sine via Taylor series, x in [0, pi/2].
    function automatic int lut_val(input int j);
        real x, term, s;
        x    = 2.0 * 3.14159265358979323846 * $itor(j) / $itor(4 * LUT_N);
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi($itor(2 ** (LO_W - 1) - 1) * s + 0.5);
    endfunction

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = (a + RND) >>> SHIFT;
        if (s > SAT_HI)      return SAT_HI[DATA_W-1:0];
        else if (s < SAT_LO) return SAT_LO[DATA_W-1:0];
        else                 return s[DATA_W-1:0];
    endfunction

    logic signed [LO_W-1:0] lut [0:LUT_N];
    for (genvar j = 0; j <= LUT_N; j++) begin : g_lut
        localparam int V = lut_val(j);
        assign lut[j] = LO_W'(V);
    end

    state_t                  state_q, state_d;
    logic [BLOCK_LOG2-1:0]   cnt_q, cnt_d;
    logic [FREQ_W-1:0]       phase_q, phase_d;
    logic [FREQ_W-1:0]       freq_q, freq_d;

    logic                    accept, blk_first, blk_last;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              quad;
    logic [LUT_ADDR_W:0]     a_dir, a_mir;
    logic signed [LO_W-1:0]  sin_mag, cos_mag, sin_lo, cos_lo;

    logic                    s1_vld, s1_first, s1_last;
    logic signed [DATA_W-1:0] s1_x;
    logic signed [LO_W-1:0]  s1_cos, s1_sin;
    logic                    s2_vld, s2_first, s2_last;
    logic signed [PROD_W-1:0] s2_pi, s2_pq, prod_i, prod_q;
    logic signed [ACC_W-1:0] acci_q, accq_q, sum_i, sum_q;
    logic signed [DATA_W-1:0] i_q, q_q;
    logic                    out_valid_q;

    assign accept    = bus.in_valid && !bus.clear;
    assign blk_first = accept && (state_q != StAcc);
    assign blk_last  = accept && (state_q == StAcc) && (&cnt_q);

    // Outside ACC the accepted sample is sample 0, whose phase is 0 by definition.
    assign idx   = (state_q == StAcc) ? phase_q[FREQ_W-1 -: IDX_W] : '0;
    assign quad  = idx[IDX_W-1 -: 2];
    assign a_dir = {1'b0, idx[LUT_ADDR_W-1:0]};
    assign a_mir = (LUT_ADDR_W + 1)'(LUT_N) - a_dir;

    always_comb begin
        sin_mag = quad[0] ? lut[a_mir] : lut[a_dir];
        cos_mag = quad[0] ? lut[a_dir] : lut[a_mir];
        sin_lo  = quad[1] ? -sin_mag : sin_mag;
        cos_lo  = (quad[1] ^ quad[0]) ? -cos_mag : cos_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        freq_d  = freq_q;
        if (bus.clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            phase_d = '0;
        end else if (blk_first) begin
            freq_d  = bus.freq;
            phase_d = bus.freq;
            cnt_d   = BLOCK_LOG2'(1);
            state_d = StAcc;
        end else if (accept) begin
            phase_d = phase_q + freq_q;
            cnt_d   = cnt_q + BLOCK_LOG2'(1);
            if (blk_last) state_d = StDrain;
        end else if (state_q == StDrain && out_valid_q) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            phase_q <= '0;
            freq_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            freq_q  <= freq_d;
        end
    end

    assign prod_i = PROD_W'(s1_x) * PROD_W'(s1_cos);
    assign prod_q = -(PROD_W'(s1_x) * PROD_W'(s1_sin));
    // First product of a block restarts the sum so back-to-back blocks need no idle cycle.
    assign sum_i  = s2_first ? ACC_W'(s2_pi) : acci_q + ACC_W'(s2_pi);
    assign sum_q  = s2_first ? ACC_W'(s2_pq) : accq_q + ACC_W'(s2_pq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
            s1_x   <= '0;   s1_cos   <= '0;   s1_sin  <= '0;
            s2_vld <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
            s2_pi  <= '0;   s2_pq    <= '0;
            acci_q <= '0;   accq_q   <= '0;
            i_q    <= '0;   q_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            s1_vld <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
            s1_x   <= '0;   s1_cos   <= '0;   s1_sin  <= '0;
            s2_vld <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
            s2_pi  <= '0;   s2_pq    <= '0;
            acci_q <= '0;   accq_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_vld   <= accept;
            s1_first <= blk_first;
            s1_last  <= blk_last;
            s1_x     <= bus.in_data;
            s1_cos   <= cos_lo;
            s1_sin   <= sin_lo;
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_pi    <= prod_i;
            s2_pq    <= prod_q;
            if (s2_vld) begin
                acci_q <= sum_i;
                accq_q <= sum_q;
            end
            out_valid_q <= s2_vld && s2_last;
            if (s2_vld && s2_last) begin
                i_q <= scale(sum_i);
                q_q <= scale(sum_q);
            end
        end
    end

    assign bus.I         = i_q;
    assign bus.Q         = q_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_single_freq_analyzer.sv
// Directed self-checking bench for single_freq_analyzer (DC, tones, saturation, gaps, aborts).
module tb_single_freq_analyzer;
    localparam int  N  = 1024;
    localparam real PI = 3.14159265358979323846;
`ifdef SINGLE_FREQ_ANALYZER_ROUND_EN
    localparam int DC_EXP = 200;
`else
    localparam int DC_EXP = 199;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc = 0;
    int   pc_q[$];
    int   pi_q[$];
    int   pq_q[$];
    int   pb_q[$];

    always #5 clk = ~clk;

    single_freq_analyzer_if bus ();
    single_freq_analyzer dut (.clk(clk), .rst(rst), .bus(bus));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            pc_q.push_back(cyc);
            pi_q.push_back(int'(bus.I));
            pq_q.push_back(int'(bus.Q));
            pb_q.push_back(int'(bus.busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic signed [31:0] obs,
                             input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // mode 0: DC amp; 1: amp*cos(2*pi*k/16); 2: amp*cos(2*pi*k/16 + pi/2)
    function automatic int sample_at(input int mode, input int amp, input int k);
        real th;
        th = 2.0 * PI * $itor(k) / 16.0;
        case (mode)
            1:       return $rtoi($floor($itor(amp) * $cos(th) + 0.5));
            2:       return $rtoi($floor($itor(amp) * $cos(th + PI / 2.0) + 0.5));
            default: return amp;
        endcase
    endfunction

    task automatic send_block(input int mode, input int amp, input logic [13:0] f,
                              input bit gaps, input int abort_at, input bit abort_rst);
        bus.freq = f;
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 10'(amp);
                if (abort_rst) begin
                    #2 rst = 1'b0;
                    #1;
                    check("rst_busy", bus.busy, 0);
                    check("rst_out_valid", bus.out_valid, 0);
                    @(posedge clk);
                    #1 rst = 1'b1;
                end else begin
                    bus.clear = 1'b1;
                    tick();
                    bus.clear = 1'b0;
                    check("clear_busy", bus.busy, 0);
                end
                bus.in_valid = 1'b0;
                break;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 10'(sample_at(mode, amp, k));
            tick();
            if (k == 0) begin
                check("busy_in_block", bus.busy, 1);
                bus.freq = ~f;  // must be ignored until the next block
            end
            if (gaps && k < N - 1) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        last_acc     = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int t = 0;
        while (pc_q.size() < target && t < 40) begin
            tick();
            t++;
        end
        check({tag, "_pulses"}, pc_q.size(), target);
    endtask

    task automatic check_result(input string tag, input int idx, input int acc_cyc,
                                input int ilo, input int ihi, input int qlo, input int qhi,
                                input int busy_exp);
        check({tag, "_latency"}, pc_q[idx], acc_cyc + 2);
        check_rng({tag, "_I"}, pi_q[idx], ilo, ihi);
        check_rng({tag, "_Q"}, pq_q[idx], qlo, qhi);
        check({tag, "_busy_at_pulse"}, pb_q[idx], busy_exp);
    endtask

    task automatic run_block(input string tag, input int mode, input int amp,
                             input logic [13:0] f, input int ilo, input int ihi,
                             input int qlo, input int qhi);
        int p0 = pc_q.size();
        send_block(mode, amp, f, 1'b0, -1, 1'b0);
        wait_pulses(tag, p0 + 1);
        check_result(tag, p0, last_acc, ilo, ihi, qlo, qhi, 1);
        repeat (5) tick();
        check({tag, "_single_pulse"}, pc_q.size(), p0 + 1);
        check({tag, "_idle_busy"}, bus.busy, 0);
        check_rng({tag, "_held_I"}, bus.I, ilo, ihi);
    endtask

    initial begin
        int p0;
        int acc1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.freq     = '0;
        repeat (3) tick();
        check("reset_outputs", {bus.I, bus.Q, bus.out_valid, bus.busy}, 0);
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check("poweron_idle", {bus.I, bus.Q, bus.out_valid, bus.busy}, 0);
        end

        run_block("dc", 0, 100, 14'd0, DC_EXP, DC_EXP, 0, 0);
        run_block("tone", 1, 400, 14'd1024, 398, 400, -2, 2);
        // x = A*cos(theta + pi/2) -> Q = A*sin(pi/2) = +A against the -sin LO
        run_block("tone90", 2, 400, 14'd1024, -2, 2, 398, 400);
        run_block("sat_pos", 0, 511, 14'd0, 511, 511, 0, 0);
        run_block("sat_neg", 0, -512, 14'd0, -512, -512, 0, 0);

        p0 = pc_q.size();
        send_block(0, 100, 14'd0, 1'b1, -1, 1'b0);
        acc1 = last_acc;
        send_block(0, 100, 14'd0, 1'b0, -1, 1'b0);
        wait_pulses("b2b", p0 + 2);
        check_result("b2b_first", p0, acc1, DC_EXP, DC_EXP, 0, 0, 1);
        check_result("b2b_second", p0 + 1, last_acc, DC_EXP, DC_EXP, 0, 0, 1);
        repeat (5) tick();
        check("b2b_count", pc_q.size(), p0 + 2);

        p0 = pc_q.size();
        send_block(0, 100, 14'd0, 1'b0, 500, 1'b0);
        repeat (10) tick();
        check("clear_no_pulse", pc_q.size(), p0);
        check("clear_hold_I", bus.I, DC_EXP);
        check("clear_hold_Q", bus.Q, 0);
        run_block("after_clear", 0, 100, 14'd0, DC_EXP, DC_EXP, 0, 0);

        p0 = pc_q.size();
        send_block(0, 100, 14'd0, 1'b0, 500, 1'b1);
        repeat (10) tick();
        check("rst_no_pulse", pc_q.size(), p0);
        check("rst_zero_IQ", {bus.I, bus.Q}, 0);
        check("rst_idle_busy", bus.busy, 0);
        run_block("after_rst", 0, 100, 14'd0, DC_EXP, DC_EXP, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
